// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory loads/stores, branch resolution and
// forwarding for the execute stage. Multi-cycle loads stall upstream via a hold register.
module mem_stage #(
    parameter int N       = 4,
    parameter int BW      = 2*N+18,
    parameter int OW      = 2*N+6,
    parameter int MEM_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [BW-1:0] bufferIn,
    output logic [OW-1:0] bufferOut,
    output logic          stall,
    output logic [N-1:0]  aluOut,
    output logic [N-1:0]  fwdData,
    output logic          branchTaken,
    output logic [N-1:0]  branchTarget
);
    localparam int         DEPTH    = 1 << N;
    localparam bit         MULTI    = (MEM_LAT > 1);
    localparam logic [N-1:0] CNT_INIT = N'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t       r_state;
    logic [N-1:0] r_cnt;
    logic [N-1:0] r_mem [DEPTH];
    logic [N-1:0] r_hold_addr;
    logic [3:0]   r_hold_rc;
    logic         r_hold_rw;

    logic [N-1:0] w_rd3;
    logic [3:0]   w_rc;
    logic         w_regWrite;
    logic         w_memToReg;
    logic         w_memWrite;
    logic         w_branch;
    logic         w_zero;
    logic [N-1:0] w_alu;
    logic         w_load;
    logic         w_store;
    logic         w_unused;

    assign w_rd3      = bufferIn[N-1:0];
    assign w_rc       = bufferIn[N+3:N];
    assign w_regWrite = bufferIn[N+12];
    assign w_memToReg = bufferIn[N+13];
    assign w_memWrite = bufferIn[N+14];
    assign w_branch   = bufferIn[N+15];
    assign w_zero     = bufferIn[N+17];
    assign w_alu      = bufferIn[2*N+17:N+18];
    assign w_unused   = ^{bufferIn[N+11:N+4], bufferIn[N+16]};

    // A load with memWrite also set is still just a load.
    assign w_load  = w_memToReg;
    assign w_store = w_memWrite & ~w_memToReg;

    assign stall        = rst & en & ((r_state == IDLE) ? (MULTI & w_load) : (r_cnt != '0));
    assign branchTaken  = rst & en & (r_state == IDLE) & w_branch & w_zero;
    assign aluOut       = w_alu;
    assign branchTarget = w_alu;
    assign fwdData      = bufferOut[5] ? bufferOut[2*N+5:N+6] : bufferOut[N+5:6];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            bufferOut   <= '0;
            r_hold_addr <= '0;
            r_hold_rc   <= '0;
            r_hold_rw   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (en) begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        if (MULTI) begin
                            r_hold_addr <= w_alu;
                            r_hold_rc   <= w_rc;
                            r_hold_rw   <= w_regWrite;
                            r_cnt       <= CNT_INIT;
                            bufferOut   <= '0;
                            r_state     <= WAIT;
                        end else begin
                            bufferOut <= {r_mem[w_alu], w_alu, 1'b1, w_regWrite, w_rc};
                        end
                    end else begin
                        if (w_store) r_mem[w_alu] <= w_rd3;
                        bufferOut <= {{N{1'b0}}, w_alu, w_memToReg, w_regWrite, w_rc};
                    end
                end
                WAIT: begin
                    // Result comes from the hold register; bufferIn is ignored here.
                    if (r_cnt != '0) begin
                        r_cnt     <= r_cnt - 1'b1;
                        bufferOut <= '0;
                    end else begin
                        bufferOut <= {r_mem[r_hold_addr], r_hold_addr, 1'b1, r_hold_rw, r_hold_rc};
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
